alu3_mdu: RTL and testbench
===========================

Name: alu3_mdu

Overview:
Parametrised multi-cycle multiply/divide unit for the next-generation CPU execute stage. It replaces the single-cycle multiply with an iterative radix-2 engine. It adds signed/unsigned high-half multiply, divide and remainder, and a start/busy/valid handshake. It emits a WIDTH-bit result plus flags in the CPU's standard flag-index layout, so the core writes back and updates flags exactly as for single-cycle ALU ops.

Parameters:
WIDTH, 32, operand/result width (even, >=8)
CNTW, $clog2(WIDTH)+1, iteration counter width (localparam, derived)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
cancel  in  1  abort current operation
op  in  3  operation code (see Behaviour)
a  in  WIDTH  first operand (multiplicand / dividend)
b  in  WIDTH  second operand (multiplier / divisor)
busy  out  1  operation in progress
valid  out  1  one-cycle pulse: res/fo are new
res  out  WIDTH  result, held until next valid
fo  out  8  flags: C/V/Z/S at CIDX/VIDX/ZIDX/SIDX, other bits 0

Behaviour:
- Reset: state=IDLE, busy=0, valid=0, res=0, fo=0, counter=0.
- Ops:
  - 000 MUL: low half of product.
  - 001 MULH: signed x signed, high half.
  - 010 MULHSU: signed a x unsigned b, high half.
  - 011 MULHU: unsigned high half.
  - 100 DIV: signed, truncating toward zero.
  - 101 DIVU.
  - 110 REM: signed, sign follows dividend.
  - 111 REMU.
- States:
  - IDLE: when start=1, latch op and operand magnitudes plus result-sign bits, counter=WIDTH, busy=1, go to CALC.
  - CALC: one shift-add (mul) or shift-restoring-subtract (div) step per cycle, counter-1; at counter==1 go to FIX.
  - FIX: apply sign correction and special cases, write res/fo, valid=1 for this cycle only, busy=0, go to IDLE.
- Latency: start sampled at edge N gives valid high in the cycle after edge N+WIDTH+1 (WIDTH+2 clocks). Latency is fixed and independent of operands.
- start while busy=1: ignored, no queuing.
- start in the same cycle as valid: accepted (back-to-back throughput WIDTH+2).
- Divide by zero:
  - DIV/DIVU: res=all ones.
  - REM/REMU: res=a.
  - V=1 in both cases; full latency still applies.
- Signed overflow (DIV/REM, a=MIN, b=-1): DIV res=MIN, REM res=0, V=1.
- Flags:
  - Z = (res==0).
  - S = res[WIDTH-1].
  - C: MUL = unsigned product exceeds WIDTH bits; MULH* = 0; div ops = 0.
  - V = set per the two special cases above, else 0.
- cancel: in any state it forces IDLE on the next edge, busy=0, no valid; res/fo keep old values. cancel takes priority over start in the same cycle.
- Reset asserted mid-operation: immediate return to reset values, no valid.
- Operands are latched at start; a/b may change during CALC without effect.

Optional Feature:
ALU3_DIV_EN
- Defined: ops 100-111 execute as above.
- Undefined:
  - Divide datapath is not built.
  - Ops 1xx complete through FIX in 2 clocks with res=0, fo V=1, other flags 0.
  - MUL ops are unchanged.

Decomposition:
- Add to defs.v:
  - MDU op code macros (MDU_MUL..MDU_REMU).
  - Flag output width.
- Reuse the existing CIDX/VIDX/ZIDX/SIDX indices.
- One sub-module, alu3_mdu_step: combinational single-iteration datapath (add-shift / trial-subtract on a 2*WIDTH accumulator). The FSM, counter and sign fix-up stay in alu3_mdu.

Test Plan (WIDTH=32, ALU3_DIV_EN defined):
- MUL a=7, b=0xFFFFFFFD -> res 0xFFFFFFEB, valid exactly 34 clocks after start. MULH same operands -> 0xFFFFFFFF. MULHU -> 0x00000006.
- DIVU 100/7 -> res 14 (0x0E), Z=0. REMU 100/7 -> 2. REMU 14/7 -> 0 with Z=1.
- DIV a=0xFFFFFFF9(-7), b=2 -> 0xFFFFFFFD, S=1. REM same operands -> 0xFFFFFFFF.
- Div by zero, a=5, b=0: DIVU -> 0xFFFFFFFF, V=1; REM -> 5, V=1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, V=1. REM same operands -> 0, Z=1, V=1.
- Handshake:
  - Second start at clock 5 is ignored.
  - cancel at clock 10 gives busy=0 next cycle, no valid, res unchanged.
  - reset pulse mid-CALC gives all outputs 0.
  - start coincident with valid is accepted.

Source files
------------

// File: rtl/alu3_mdu_pkg.sv
// Shared definitions for the alu3 multiply/divide unit: FSM states, op codes
// and the CPU flag-index layout. Divide support is selected with ALU3_DIV_EN.
package alu3_mdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam int FLAGW = 8;
  localparam int CIDX  = 0;
  localparam int VIDX  = 1;
  localparam int ZIDX  = 2;
  localparam int SIDX  = 3;

  function automatic logic [FLAGW-1:0] mk_flags(input logic c, input logic v,
                                                input logic z, input logic s);
    mk_flags       = '0;
    mk_flags[CIDX] = c;
    mk_flags[VIDX] = v;
    mk_flags[ZIDX] = z;
    mk_flags[SIDX] = s;
  endfunction

endpackage

// File: rtl/alu3_mdu_step.sv
// One radix-2 iteration on the 2*WIDTH accumulator: shift-add for multiply,
// shift and trial-subtract for divide (divide path only with ALU3_DIV_EN).
module alu3_mdu_step #(
  parameter int WIDTH = 32
) (
`ifdef ALU3_DIV_EN
  input  logic               is_div,
`endif
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
`ifdef ALU3_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
`endif

  always_comb begin
    // Multiplier bits sit in the low half and are consumed LSB first.
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    acc_o = {sum, acc_i[WIDTH-1:1]};
`ifdef ALU3_DIV_EN
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, opnd_i};
    diff   = rem_sh[WIDTH-1:0] - opnd_i;
    if (is_div) begin
      acc_o = {(ge ? diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/alu3_mdu.sv
// Iterative multiply/divide unit with start/busy/valid handshake and CPU flags.
// Define ALU3_DIV_EN to build the divide/remainder datapath.
module alu3_mdu
  import alu3_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] res,
  output logic [FLAGW-1:0] fo
);

  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [FLAGW-1:0]   fo_q, fo_d;
  logic               valid_q, valid_d;
`ifdef ALU3_DIV_EN
  logic [WIDTH-1:0]   a_q, a_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic               sd;
`endif
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   fix_res, mul_hi;
  logic [FLAGW-1:0]   fix_fo;
  logic               fix_c, fix_v;

  alu3_mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef ALU3_DIV_EN
    .is_div (op_q[2]),
`endif
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Sign correction and special cases, consumed in FIX.
  always_comb begin
    mul_hi  = neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(acc_q[WIDTH-1:0] == '0))
                    : acc_q[2*WIDTH-1:WIDTH];
    fix_res = '0;
    fix_c   = 1'b0;
    fix_v   = 1'b0;
    if (!op_q[2]) begin
      if (op_q == MDU_MUL) begin
        fix_res = acc_q[WIDTH-1:0];
        fix_c   = |acc_q[2*WIDTH-1:WIDTH];
      end else begin
        fix_res = mul_hi;
      end
    end else begin
`ifdef ALU3_DIV_EN
      if (dz_q) begin
        fix_v   = 1'b1;
        fix_res = op_q[1] ? a_q : '1;
      end else begin
        fix_v   = ovf_q;
        fix_res = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        if (neg_q) fix_res = -fix_res;
      end
`else
      fix_v = 1'b1;
`endif
    end
    fix_fo = mk_flags(fix_c, fix_v, fix_res == '0, fix_res[WIDTH-1]);
`ifndef ALU3_DIV_EN
    if (op_q[2]) fix_fo = mk_flags(1'b0, 1'b1, 1'b0, 1'b0);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    res_d   = res_q;
    fo_d    = fo_q;
    valid_d = 1'b0;
    a_sgn   = 1'b0;
    b_sgn   = 1'b0;
`ifdef ALU3_DIV_EN
    a_d     = a_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    sd      = ~op[0];
`endif
    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d    = op;
            cnt_d   = CNTW'(WIDTH);
            state_d = ST_CALC;
            if (!op[2]) begin
              a_sgn  = a[WIDTH-1] & ((op == MDU_MULH) | (op == MDU_MULHSU));
              b_sgn  = b[WIDTH-1] & (op == MDU_MULH);
              opnd_d = a_sgn ? -a : a;
              acc_d  = {{WIDTH{1'b0}}, (b_sgn ? -b : b)};
              neg_d  = a_sgn ^ b_sgn;
            end else begin
`ifdef ALU3_DIV_EN
              a_sgn  = sd & a[WIDTH-1];
              b_sgn  = sd & b[WIDTH-1];
              opnd_d = b_sgn ? -b : b;
              acc_d  = {{WIDTH{1'b0}}, (a_sgn ? -a : a)};
              neg_d  = op[1] ? a_sgn : (a_sgn ^ b_sgn);
              a_d    = a;
              dz_d   = (b == '0);
              ovf_d  = sd & (a == MIN_VAL) & (b == '1);
`else
              state_d = ST_FIX;
`endif
            end
          end
        end
        ST_CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          res_d   = fix_res;
          fo_d    = fix_fo;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      fo_q    <= '0;
      valid_q <= 1'b0;
`ifdef ALU3_DIV_EN
      a_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      fo_q    <= fo_d;
      valid_q <= valid_d;
`ifdef ALU3_DIV_EN
      a_q     <= a_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = valid_q;
  assign res   = res_q;
  assign fo    = fo_q;

endmodule

// File: tb/tb_alu3_mdu.sv
// Scoreboard bench for alu3_mdu (WIDTH=32); expectations follow ALU3_DIV_EN.
module tb_alu3_mdu;
  import alu3_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, valid;
  logic [W-1:0] res;
  logic [7:0]   fo;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic [7:0]   fo;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0, n_err = 0, n_valid = 0, n_exp = 0, cyc = 0;
  logic [W-1:0] last_res = '0;

  alu3_mdu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cancel (cancel),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .valid  (valid),
    .res    (res),
    .fo     (fo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] o);
`ifdef ALU3_DIV_EN
    lat_of = W + 2;
`else
    lat_of = o[2] ? 2 : W + 2;
`endif
  endfunction

  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [7:0] f);
    logic [63:0] p;
    logic c, v, stub;
    c = 1'b0; v = 1'b0; stub = 1'b0; r = '0; p = '0;
    case (o)
      MDU_MUL:    begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; c = (p[63:32] != 0); end
      MDU_MULH:   begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[63:32]; end
      MDU_MULHSU: begin p = {{32{x[31]}}, x} * {32'd0, y}; r = p[63:32]; end
      MDU_MULHU:  begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
      MDU_DIV: begin
        if (y == 0) begin r = '1; v = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = x; v = 1'b1; end
        else r = $signed(x) / $signed(y);
      end
      MDU_DIVU: begin
        if (y == 0) begin r = '1; v = 1'b1; end
        else r = x / y;
      end
      MDU_REM: begin
        if (y == 0) begin r = x; v = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin r = '0; v = 1'b1; end
        else r = $signed(x) % $signed(y);
      end
      default: begin
        if (y == 0) begin r = x; v = 1'b1; end
        else r = x % y;
      end
    endcase
`ifndef ALU3_DIV_EN
    if (o[2]) begin r = '0; v = 1'b1; stub = 1'b1; end
`endif
    f = '0;
    f[CIDX] = c;
    f[VIDX] = v;
    f[ZIDX] = (r == 0) && !stub;
    f[SIDX] = r[31];
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (reset && valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_res"}, 64'(res), 64'(e.res));
        check({e.tag, "_fo"}, 64'(fo), 64'(e.fo));
        check({e.tag, "_lat"}, 64'(cyc), 64'(e.due));
        last_res = e.res;
      end
    end
  end

  // Caller is at a negedge; drives start for one cycle, then scrambles operands.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input string tag);
    exp_t e;
    logic [W-1:0] r;
    logic [7:0]   f;
    model(o, xa, xb, r, f);
    e.tag = tag; e.res = r; e.fo = f; e.due = cyc + lat_of(o);
    sb.push_back(e);
    n_exp++;
    start = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                     input string tag);
    issue(o, xa, xb, tag);
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int due;
    exp_t dropped;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_fo", 64'(fo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run(MDU_MUL,    32'd7, 32'hFFFF_FFFD, "mul");
    run(MDU_MULH,   32'd7, 32'hFFFF_FFFD, "mulh");
    run(MDU_MULHU,  32'd7, 32'hFFFF_FFFD, "mulhu");
    run(MDU_MULHSU, 32'hFFFF_FFF9, 32'hFFFF_FFFD, "mulhsu");
    run(MDU_DIVU,   32'd100, 32'd7, "divu");
    run(MDU_REMU,   32'd100, 32'd7, "remu");
    run(MDU_REMU,   32'd14, 32'd7, "remu_z");
    run(MDU_DIV,    32'hFFFF_FFF9, 32'd2, "div_neg");
    run(MDU_REM,    32'hFFFF_FFF9, 32'd2, "rem_neg");
    run(MDU_DIVU,   32'd5, 32'd0, "divu_dz");
    run(MDU_REM,    32'd5, 32'd0, "rem_dz");
    run(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    for (int i = 0; i < 8; i++)
      run(3'(i), $urandom, (i[0] ? 32'($urandom_range(1, 300)) : $urandom), "rnd");

    // Second start while busy must be dropped.
    issue(MDU_MUL, 32'd3, 32'd5, "busy_ign");
    repeat (3) @(negedge clk);
    start = 1'b1; op = MDU_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    check("busy_during", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // Cancel mid-CALC: no valid, result held.
    issue(MDU_MUL, 32'd9, 32'd9, "cancel");
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    dropped = sb.pop_back();
    n_exp--;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_res", 64'(res), 64'(last_res));
    repeat (40) @(negedge clk);

    // Cancel beats a simultaneous start.
    start = 1'b1; cancel = 1'b1; op = MDU_MUL; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_prio_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Reset pulse mid-CALC clears everything at once.
    issue(MDU_MULHU, 32'hFFFF_FFFF, 32'd3, "reset_mid");
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    dropped = sb.pop_back();
    n_exp--;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_res", 64'(res), 64'd0);
    check("midrst_fo", 64'(fo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // start in the valid cycle is accepted.
    due = cyc + lat_of(MDU_MUL);
    issue(MDU_MUL, 32'd6, 32'd7, "b2b_first");
    while (cyc < due) @(negedge clk);
    check("b2b_valid", 64'(valid), 64'd1);
    issue(MDU_DIVU, 32'd1000, 32'd10, "b2b_second");
    wait_idle();
    repeat (10) @(negedge clk);

    check("valid_count", 64'(n_valid), 64'(n_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
